// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg : shared state encoding and default drive scale constants
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package elevator_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACCEL  = 3'd1;
  localparam logic [2:0] CRUISE = 3'd2;
  localparam logic [2:0] DECEL  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_ACCEL  = ACCEL,
    ST_CRUISE = CRUISE,
    ST_DECEL  = DECEL,
    ST_DONE   = DONE
  } motor_state_e;

  localparam logic [31:0] DEF_SCALE_SLOW  = 32'd2_500_000;
  localparam logic [31:0] DEF_SCALE_FAST  = 32'd250_000;
  localparam logic [31:0] DEF_SCALE_DELTA = 32'd250_000;
  localparam int          DEF_RAMP_STEPS  = 8;

endpackage

`default_nettype wire

// File: rtl/motor_profile_ctrl_scale_ramp.sv
// ---------------------------------------------------------------------------
// scale_ramp : one ramp level of divider scale, clamped to [FAST, SLOW]
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scale_ramp #(
  parameter logic [31:0] SCALE_SLOW  = 32'd2_500_000,
  parameter logic [31:0] SCALE_FAST  = 32'd250_000,
  parameter logic [31:0] SCALE_DELTA = 32'd250_000
) (
  input  logic        up,
  input  logic        down,
  input  logic [31:0] cur,
  output logic [31:0] nxt
);

  logic [31:0] room_dn;
  logic [31:0] room_up;

  // Headroom to each clamp is measured first so neither add nor subtract can wrap.
  always_comb begin
    room_dn = (cur > SCALE_FAST) ? (cur - SCALE_FAST) : 32'd0;
    room_up = (cur < SCALE_SLOW) ? (SCALE_SLOW - cur) : 32'd0;
    nxt     = cur;
    if (down) begin
      nxt = (room_dn > SCALE_DELTA) ? (cur - SCALE_DELTA) : SCALE_FAST;
    end else if (up) begin
      nxt = (room_up > SCALE_DELTA) ? (cur + SCALE_DELTA) : SCALE_SLOW;
    end
  end

endmodule

`default_nettype wire

// File: rtl/motor_profile_ctrl.sv
// ---------------------------------------------------------------------------
// motor_profile_ctrl : trapezoidal step-rate sequencer for the cab drive
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module motor_profile_ctrl
  import elevator_pkg::*;
#(
  parameter logic [31:0] SCALE_SLOW  = DEF_SCALE_SLOW,
  parameter logic [31:0] SCALE_FAST  = DEF_SCALE_FAST,
  parameter logic [31:0] SCALE_DELTA = DEF_SCALE_DELTA,
  parameter int          RAMP_STEPS  = DEF_RAMP_STEPS
) (
  input  logic        CCLK,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dist_steps,
  input  logic        abort,
  input  logic        step_edge,
  output logic [31:0] clk_scale,
  output logic        motor_en,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [2:0]  state
);

  localparam int            RW        = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_STEPS - 1);

  motor_state_e  state_q;
  logic [15:0]   remaining_q;
  logic [15:0]   accel_q;
  logic [RW-1:0] ramp_cnt_q;
  logic [31:0]   clk_scale_q;
  logic          motor_en_q;
  logic          busy_q;
  logic          done_q;
  logic          aborted_q;

  logic [15:0]   rem_d;
  logic [15:0]   accel_d;
  logic [15:0]   accel_cmp;
  logic          ramp_wrap;
  logic [31:0]   ramp_scale;

  assign rem_d     = remaining_q - 16'd1;
  assign accel_d   = (&accel_q) ? accel_q : (accel_q + 16'd1);
  assign accel_cmp = (state_q == ST_ACCEL) ? accel_d : accel_q;
  assign ramp_wrap = (ramp_cnt_q == RAMP_LAST);

  scale_ramp #(
    .SCALE_SLOW (SCALE_SLOW),
    .SCALE_FAST (SCALE_FAST),
    .SCALE_DELTA(SCALE_DELTA)
  ) u_scale_ramp (
    .up  (state_q == ST_DECEL),
    .down(state_q == ST_ACCEL),
    .cur (clk_scale_q),
    .nxt (ramp_scale)
  );

  always_ff @(posedge CCLK) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      accel_q     <= '0;
      ramp_cnt_q  <= '0;
      clk_scale_q <= SCALE_SLOW;
      motor_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (abort && (state_q != ST_IDLE)) begin
        state_q     <= ST_IDLE;
        clk_scale_q <= SCALE_SLOW;
        motor_en_q  <= 1'b0;
        busy_q      <= 1'b0;
        aborted_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && !abort) begin
              busy_q <= 1'b1;
              if (dist_steps != 16'd0) begin
                state_q     <= ST_ACCEL;
                remaining_q <= dist_steps;
                accel_q     <= '0;
                ramp_cnt_q  <= '0;
                motor_en_q  <= 1'b1;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            motor_en_q  <= 1'b0;
            clk_scale_q <= SCALE_SLOW;
          end
          default: begin
            if (step_edge) begin
              remaining_q <= rem_d;
              if (rem_d == 16'd0) begin
                state_q     <= ST_DONE;
                done_q      <= 1'b1;
                motor_en_q  <= 1'b0;
                clk_scale_q <= SCALE_SLOW;
              end else begin
                ramp_cnt_q <= ramp_wrap ? '0 : (ramp_cnt_q + RW'(1));
                if (state_q == ST_ACCEL) begin
                  accel_q <= accel_d;
                  if (ramp_wrap) begin
                    clk_scale_q <= ramp_scale;
                    if (ramp_scale == SCALE_FAST) state_q <= ST_CRUISE;
                  end
                end
                if ((state_q == ST_DECEL) && ramp_wrap) clk_scale_q <= ramp_scale;
                // Later assignment wins: braking point overrides the cruise entry.
                if ((state_q != ST_DECEL) && (rem_d <= accel_cmp)) begin
                  state_q    <= ST_DECEL;
                  ramp_cnt_q <= '0;
                end
              end
            end
          end
        endcase
      end
    end
  end

  assign clk_scale = clk_scale_q;
  assign motor_en  = motor_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_motor_profile_ctrl.sv
// ---------------------------------------------------------------------------
// tb_motor_profile_ctrl : directed self-checking bench for motor_profile_ctrl
// Revision              : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_motor_profile_ctrl;

  logic        CCLK = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dist_steps = 16'd0;
  logic        abort = 1'b0;
  logic        step_edge = 1'b0;
  logic [31:0] clk_scale;
  logic        motor_en;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;

  int full_scale [20] = '{8,6,6,4,4,2,2,2,2,2,2,2,2,2,2,4,4,6,6,8};
  int full_state [20] = '{1,1,1,1,1,2,2,2,2,2,2,2,2,3,3,3,3,3,3,4};
  int short_scale[4]  = '{8,6,6,8};
  int short_state[4]  = '{1,3,3,4};

  motor_profile_ctrl #(
    .SCALE_SLOW (32'd8),
    .SCALE_FAST (32'd2),
    .SCALE_DELTA(32'd2),
    .RAMP_STEPS (2)
  ) dut (
    .CCLK      (CCLK),
    .rst       (rst),
    .start     (start),
    .dist_steps(dist_steps),
    .abort     (abort),
    .step_edge (step_edge),
    .clk_scale (clk_scale),
    .motor_en  (motor_en),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .state     (state)
  );

  always #5 CCLK = ~CCLK;

  task automatic tick();
    @(posedge CCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_step();
    step_edge = 1'b1;
    tick();
    step_edge = 1'b0;
  endtask

  task automatic start_trip(input logic [15:0] d);
    dist_steps = d;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " scale"},   clk_scale, 32'd8);
    check({tag, " motor"},   {31'd0, motor_en}, 32'd0);
    check({tag, " busy"},    {31'd0, busy}, 32'd0);
    check({tag, " done"},    {31'd0, done}, 32'd0);
    check({tag, " aborted"}, {31'd0, aborted}, 32'd0);
    check({tag, " state"},   {29'd0, state}, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Full trip with a stray start in the middle of cruise.
    start_trip(16'd20);
    check("full start state", {29'd0, state}, 32'd1);
    check("full start busy",  {31'd0, busy}, 32'd1);
    check("full start motor", {31'd0, motor_en}, 32'd1);
    check("full start scale", clk_scale, 32'd8);
    for (int e = 1; e <= 20; e++) begin
      do_step();
      check($sformatf("full e%0d scale", e), clk_scale, 32'(full_scale[e-1]));
      check($sformatf("full e%0d state", e), {29'd0, state}, 32'(full_state[e-1]));
      if (e == 20) break;
      if (e == 9) begin
        dist_steps = 16'd5;
        start      = 1'b1;
      end
      tick();
      start = 1'b0;
      tick();
      tick();
    end
    check("full done pulse",  {31'd0, done}, 32'd1);
    check("full done motor",  {31'd0, motor_en}, 32'd0);
    tick();
    check("full after done",  {31'd0, done}, 32'd0);
    check("full idle state",  {29'd0, state}, 32'd0);
    check("full idle busy",   {31'd0, busy}, 32'd0);

    // Short trip never cruises.
    start_trip(16'd4);
    for (int e = 1; e <= 4; e++) begin
      do_step();
      check($sformatf("short e%0d scale", e), clk_scale, 32'(short_scale[e-1]));
      check($sformatf("short e%0d state", e), {29'd0, state}, 32'(short_state[e-1]));
      if (e == 4) break;
      tick();
      tick();
      tick();
    end
    check("short done", {31'd0, done}, 32'd1);
    tick();
    check("short idle", {29'd0, state}, 32'd0);

    // One-step trip.
    start_trip(16'd1);
    check("d1 accel", {29'd0, state}, 32'd1);
    do_step();
    check("d1 state", {29'd0, state}, 32'd4);
    check("d1 scale", clk_scale, 32'd8);
    check("d1 done",  {31'd0, done}, 32'd1);
    tick();
    check("d1 idle",  {29'd0, state}, 32'd0);

    // Zero-length trip.
    start_trip(16'd0);
    check("d0 state", {29'd0, state}, 32'd4);
    check("d0 done",  {31'd0, done}, 32'd1);
    check("d0 motor", {31'd0, motor_en}, 32'd0);
    check("d0 busy",  {31'd0, busy}, 32'd1);
    tick();
    check("d0 idle",       {29'd0, state}, 32'd0);
    check("d0 done clear", {31'd0, done}, 32'd0);
    check("d0 motor idle", {31'd0, motor_en}, 32'd0);

    // Abort coincident with step edge 8.
    start_trip(16'd20);
    for (int e = 1; e <= 7; e++) begin
      do_step();
      tick();
      tick();
      tick();
    end
    check("abort pre state", {29'd0, state}, 32'd2);
    abort = 1'b1;
    do_step();
    abort = 1'b0;
    check("abort state",   {29'd0, state}, 32'd0);
    check("abort scale",   clk_scale, 32'd8);
    check("abort pulse",   {31'd0, aborted}, 32'd1);
    check("abort done",    {31'd0, done}, 32'd0);
    check("abort motor",   {31'd0, motor_en}, 32'd0);
    check("abort busy",    {31'd0, busy}, 32'd0);
    tick();
    check("abort pulse end", {31'd0, aborted}, 32'd0);
    check("abort no done",   {31'd0, done}, 32'd0);

    // Abort in IDLE blocks start and does nothing else.
    abort      = 1'b1;
    dist_steps = 16'd5;
    start      = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("idle abort state",   {29'd0, state}, 32'd0);
    check("idle abort aborted", {31'd0, aborted}, 32'd0);

    // Reset in cruise.
    start_trip(16'd20);
    for (int e = 1; e <= 6; e++) begin
      do_step();
      tick();
      tick();
      tick();
    end
    check("rst pre state", {29'd0, state}, 32'd2);
    check("rst pre scale", clk_scale, 32'd2);
    rst = 1'b1;
    tick();
    check_reset_outputs("rst cruise");
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
